// File: rtl/sic4_pkg.sv
// Shared types and helpers for the SIC-4 immediate builder.
//   state_e  : builder FSM states (EMPTY, ACCUM, HOLD)
//   EXT_*    : extension-mode encodings for the in_signed input
//   cnt_w()  : width of a counter that must reach max_chunks inclusive
package sic4_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  function automatic int cnt_w(input int max_chunks);
    return $clog2(max_chunks + 1);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extender: widens the assembled immediate to OUT_W bits.
//   acc   : assembled chunks, right-aligned (first chunk most significant)
//   count : number of valid chunks in acc (k = count*IN_W valid bits)
//   sgn   : EXT_SIGN replicates bit k-1 upward, EXT_ZERO fills with zeros
//   ext   : OUT_W-bit extended value
module imm_ext_core
  import sic4_pkg::*;
#(
  parameter int IN_W       = 2,
  parameter int OUT_W      = 8,
  parameter int MAX_CHUNKS = 4,
  localparam int AW        = MAX_CHUNKS * IN_W,
  localparam int CW        = cnt_w(MAX_CHUNKS)
) (
  input  logic [AW-1:0]    acc,
  input  logic [CW-1:0]    count,
  input  logic             sgn,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] acc_pad;
  logic             fill;
  int               k;

  always_comb begin
    ext     = '0;
    acc_pad = OUT_W'(acc);
    k       = int'(count) * IN_W;
    // Fill bit is the top valid bit when sign-extending; k=0 leaves it zero.
    fill    = 1'b0;
    for (int j = 0; j < AW; j++)
      if (sgn == EXT_SIGN && j == k - 1) fill = acc[j];
    for (int i = 0; i < OUT_W; i++)
      ext[i] = (i < k) ? acc_pad[i] : fill;
  end

endmodule

// File: rtl/imm_builder.sv
// Immediate builder: accumulates IN_W-bit chunks (MS chunk first) and emits
// an OUT_W-bit sign/zero-extended immediate through a ready/valid handshake.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop any partial or held immediate
//   in_valid/ready  : chunk handshake; in_chunk, in_last, in_signed payload
//   out_valid/ready : result handshake; out_data, out_overflow payload
//   out_overflow    : immediate was closed at MAX_CHUNKS without in_last
module imm_builder
  import sic4_pkg::*;
#(
  parameter int IN_W       = 2,
  parameter int OUT_W      = 8,
  parameter int MAX_CHUNKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_chunk,
  input  logic             in_last,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_overflow
);

  localparam int AW = MAX_CHUNKS * IN_W;
  localparam int CW = cnt_w(MAX_CHUNKS);

  if (AW > OUT_W) begin : g_width_chk
    $error("imm_builder: MAX_CHUNKS*IN_W must not exceed OUT_W");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    acc_base, acc_new;
  logic [CW-1:0]    cnt_base, cnt_new;
  logic             accept, complete;
  logic [OUT_W-1:0] ext_val;

  assign in_ready     = (state_q != HOLD) | out_ready;
  assign accept       = in_valid & in_ready;
  assign out_valid    = (state_q == HOLD);
  assign out_data     = out_data_q;
  assign out_overflow = ovf_q;

  // Extender sees the post-accept accumulator so the result can be
  // registered on the same edge that takes the completing chunk.
  imm_ext_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MAX_CHUNKS(MAX_CHUNKS)
  ) u_ext (
    .acc  (acc_new),
    .count(cnt_new),
    .sgn  (in_signed),
    .ext  (ext_val)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;

    // An accept while in HOLD implies out_ready, so it starts a fresh
    // immediate rather than extending the one being handed off.
    acc_base = (state_q == HOLD) ? '0 : acc_q;
    cnt_base = (state_q == HOLD) ? '0 : count_q;
    acc_new  = (acc_base << IN_W) | AW'(in_chunk);
    cnt_new  = cnt_base + CW'(1);
    complete = in_last | (cnt_new == CW'(MAX_CHUNKS));

    if (flush) begin
      state_d = EMPTY;
      acc_d   = '0;
      count_d = '0;
    end else if (accept) begin
      if (complete) begin
        state_d    = HOLD;
        acc_d      = '0;
        count_d    = '0;
        out_data_d = ext_val;
        ovf_d      = ~in_last;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_new;
        count_d = cnt_new;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      acc_q      <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_imm_builder.sv
// Self-checking bench for imm_builder: one instance at IN_W=2/OUT_W=8 and
// one at IN_W=4/OUT_W=16, table-driven vectors plus directed sequences.
module tb_imm_builder;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_last, a_in_signed;
  logic        a_out_valid, a_out_ready, a_out_ovf;
  logic [1:0]  a_in_chunk;
  logic [7:0]  a_out_data;

  logic        b_in_valid, b_in_ready, b_in_last, b_in_signed;
  logic        b_out_valid, b_out_ready, b_out_ovf;
  logic [3:0]  b_in_chunk;
  logic [15:0] b_out_data;

  imm_builder #(.IN_W(2), .OUT_W(8), .MAX_CHUNKS(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_chunk(a_in_chunk),
    .in_last(a_in_last), .in_signed(a_in_signed),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_overflow(a_out_ovf)
  );

  imm_builder #(.IN_W(4), .OUT_W(16), .MAX_CHUNKS(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_chunk(b_in_chunk),
    .in_last(b_in_last), .in_signed(b_in_signed),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_overflow(b_out_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // chunks in issue order: chunk i = ch[15-4*i -: 4]
  typedef struct {
    int          dut;
    int          n;
    logic [15:0] ch;
    logic        last;
    logic        sgn;
    logic [15:0] exp;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(int dut, int n, logic [15:0] ch, logic last,
                              logic sgn, logic [15:0] exp, logic ovf, string name);
    vec_t v;
    v.dut = dut; v.n = n; v.ch = ch; v.last = last; v.sgn = sgn;
    v.exp = exp; v.ovf = ovf; v.name = name;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(int dut, logic v, logic [3:0] c, logic l, logic s, logic r);
    if (dut == 0) begin
      a_in_valid = v; a_in_chunk = c[1:0]; a_in_last = l; a_in_signed = s; a_out_ready = r;
    end else begin
      b_in_valid = v; b_in_chunk = c; b_in_last = l; b_in_signed = s; b_out_ready = r;
    end
  endtask

  function automatic logic [15:0] odata(int dut);
    return (dut == 0) ? {8'h00, a_out_data} : b_out_data;
  endfunction
  function automatic logic ovalid(int dut);
    return (dut == 0) ? a_out_valid : b_out_valid;
  endfunction
  function automatic logic oovf(int dut);
    return (dut == 0) ? a_out_ovf : b_out_ovf;
  endfunction
  function automatic logic iready(int dut);
    return (dut == 0) ? a_in_ready : b_in_ready;
  endfunction

  task automatic apply(vec_t v);
    logic [15:0] ch;
    ch = v.ch;
    for (int i = 0; i < v.n; i++) begin
      drive(v.dut, 1'b1, ch[15-4*i -: 4], v.last && (i == v.n - 1), v.sgn, 1'b0);
      tick();
    end
    drive(v.dut, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk({v.name, "_valid"}, 16'(ovalid(v.dut)), 16'h1);
    chk({v.name, "_data"},  odata(v.dut), v.exp);
    chk({v.name, "_ovf"},   16'(oovf(v.dut)), 16'(v.ovf));
    drive(v.dut, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(v.dut, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk({v.name, "_drained"}, 16'(ovalid(v.dut)), 16'h0);
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 16'h2000, 1, 1, 16'h00FE, 0, "a_1chunk_s");
    vecs[1]  = mk(0, 1, 16'h2000, 1, 0, 16'h0002, 0, "a_1chunk_u");
    vecs[2]  = mk(0, 3, 16'h1230, 1, 1, 16'h001B, 0, "a_3chunk_s");
    vecs[3]  = mk(0, 2, 16'h3100, 1, 1, 16'h00FD, 0, "a_2chunk_s");
    vecs[4]  = mk(0, 2, 16'h3100, 1, 0, 16'h000D, 0, "a_2chunk_u");
    vecs[5]  = mk(0, 4, 16'h3012, 0, 1, 16'h00C6, 1, "a_overflow");
    vecs[6]  = mk(0, 4, 16'h2001, 1, 1, 16'h0081, 0, "a_4chunk_last");
    vecs[7]  = mk(1, 1, 16'h8000, 1, 1, 16'hFFF8, 0, "b_1chunk_s");
    vecs[8]  = mk(1, 1, 16'h8000, 1, 0, 16'h0008, 0, "b_1chunk_u");
    vecs[9]  = mk(1, 3, 16'h1AF0, 1, 1, 16'h01AF, 0, "b_3chunk_s");
    vecs[10] = mk(1, 2, 16'hF100, 1, 1, 16'hFFF1, 0, "b_2chunk_s");
    vecs[11] = mk(1, 2, 16'hF100, 1, 0, 16'h00F1, 0, "b_2chunk_u");
    vecs[12] = mk(1, 4, 16'h1234, 0, 1, 16'h1234, 1, "b_overflow");

    rst = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_a_valid", 16'(a_out_valid), 16'h0);
    chk("rst_a_data",  {8'h00, a_out_data}, 16'h0);
    chk("rst_a_ovf",   16'(a_out_ovf), 16'h0);
    chk("rst_a_ready", 16'(a_in_ready), 16'h1);
    chk("rst_b_valid", 16'(b_out_valid), 16'h0);
    chk("rst_b_data",  b_out_data, 16'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) apply(vecs[i]);

    // Backpressure: a blocked chunk must not disturb the held result.
    drive(0, 1, 4'h2, 1, 1, 0);
    tick();
    drive(0, 1, 4'h3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 16'(a_out_valid), 16'h1);
      chk("bp_data",  {8'h00, a_out_data}, 16'h00FE);
      chk("bp_ready", 16'(a_in_ready), 16'h0);
    end
    drive(0, 1, 4'h1, 1, 0, 1);
    #1;
    chk("bp_ready_on_take", 16'(a_in_ready), 16'h1);
    tick();
    chk("b2b_valid", 16'(a_out_valid), 16'h1);
    chk("b2b_data",  {8'h00, a_out_data}, 16'h0001);
    // Consume with a non-completing chunk: fresh immediate, no residue.
    drive(0, 1, 4'h3, 0, 0, 1);
    tick();
    chk("hold_to_accum_valid", 16'(a_out_valid), 16'h0);
    drive(0, 1, 4'h1, 1, 1, 0);
    tick();
    chk("hold_to_accum_data", {8'h00, a_out_data}, 16'h00FD);
    drive(0, 0, 0, 0, 0, 1);
    tick();

    // Flush mid-accumulate, with a same-cycle chunk that must be dropped.
    drive(0, 1, 4'h3, 0, 0, 0); tick();
    drive(0, 1, 4'h2, 0, 0, 0); tick();
    flush = 1'b1;
    drive(0, 1, 4'h3, 1, 1, 0); tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_valid", 16'(a_out_valid), 16'h0);
    tick();
    chk("flush_valid2", 16'(a_out_valid), 16'h0);
    drive(0, 1, 4'h1, 1, 0, 0); tick();
    chk("post_flush_valid", 16'(a_out_valid), 16'h1);
    chk("post_flush_data",  {8'h00, a_out_data}, 16'h0001);
    drive(0, 0, 0, 0, 0, 1); tick();

    // ACCUM waits indefinitely for the next chunk.
    drive(0, 1, 4'h2, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("accum_idle_valid", 16'(a_out_valid), 16'h0);
    end
    drive(0, 1, 4'h1, 1, 1, 0); tick();
    chk("accum_resume_data", {8'h00, a_out_data}, 16'h00F9);
    drive(0, 0, 0, 0, 0, 1); tick();

    // Reset while holding a result.
    drive(0, 1, 4'h2, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_data", {8'h00, a_out_data}, 16'h00FE);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("hold_rst_valid", 16'(a_out_valid), 16'h0);
    chk("hold_rst_data",  {8'h00, a_out_data}, 16'h0);
    chk("hold_rst_ready", 16'(a_in_ready), 16'h1);
    chk("hold_rst_ovf",   16'(a_out_ovf), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
